// File: rtl/sar_adc_pkg.sv
// rtl/sar_adc_pkg.sv - shared state encoding and channel-pick helper for the SAR scan sequencer
package sar_adc_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, CONV, DONE} state_e;

  localparam int MAX_CH = 32;

  typedef struct packed {
    logic       found;
    logic [4:0] ch;
  } ch_pick_t;

  // Lowest set channel strictly above 'from'; from = -1 picks the lowest set channel.
  function automatic ch_pick_t next_ch(input logic [MAX_CH-1:0] mask, input int from);
    ch_pick_t p;
    p = '0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (i > from && mask[i]) begin
        p.found = 1'b1;
        p.ch    = 5'(i);
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/sar_adc_core.sv
// rtl/sar_adc_core.sv - successive-approximation bit pointer and DAC trial/result registers
import sar_adc_pkg::*;

module sar_adc_core #(
  parameter int ADC_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 step,
  input  logic                 cmp,
  output logic [ADC_WIDTH-1:0] DACF,
  output logic [ADC_WIDTH-1:0] result,
  output logic                 last_bit
);

  localparam int PW = $clog2(ADC_WIDTH);

  logic [ADC_WIDTH-1:0] dacf_q, dacf_d;
  logic [ADC_WIDTH-1:0] result_q, result_d;
  logic [PW-1:0]        ptr_q, ptr_d;

  // load wins over step so a back-to-back repetition can restart on the LSB cycle
  always_comb begin
    dacf_d   = dacf_q;
    result_d = result_q;
    ptr_d    = ptr_q;
    if (load) begin
      dacf_d                = '0;
      dacf_d[ADC_WIDTH-1]   = 1'b1;
      result_d              = '0;
      ptr_d                 = PW'(ADC_WIDTH - 1);
    end else if (step) begin
      result_d[ptr_q] = cmp;
      if (ptr_q != '0) begin
        dacf_d                         = result_d;
        dacf_d[PW'(ptr_q - 1'b1)]      = 1'b1;
        ptr_d                          = PW'(ptr_q - 1'b1);
      end else begin
        dacf_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dacf_q   <= '0;
      result_q <= '0;
      ptr_q    <= '0;
    end else begin
      dacf_q   <= dacf_d;
      result_q <= result_d;
      ptr_q    <= ptr_d;
    end
  end

  assign DACF     = dacf_q;
  assign result   = result_q;
  assign last_bit = (ptr_q == '0);

endmodule

// File: rtl/sar_adc_seq.sv
// rtl/sar_adc_seq.sv - multi-channel SAR scan sequencer; SAR_AVG_EN enables per-channel averaging
import sar_adc_pkg::*;

module sar_adc_seq #(
  parameter int ADC_WIDTH  = 8,
  parameter int CH_NUM     = 4,
  parameter int SETTLE_CYC = 2,
  parameter int AVG_LOG2   = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      cont,
  input  logic [CH_NUM-1:0]         ch_mask,
  input  logic                      cmp,
  output logic [ADC_WIDTH-1:0]      DACF,
  output logic [$clog2(CH_NUM)-1:0] mux_sel,
  output logic                      busy,
  output logic                      eoc,
  output logic                      den,
  output logic [ADC_WIDTH-1:0]      Dout,
  output logic [$clog2(CH_NUM)-1:0] Dch,
  output logic                      scan_done
);

  localparam int CW   = $clog2(CH_NUM);
  localparam int SETW = $clog2(SETTLE_CYC) + 1;

  state_e               state_q, state_d;
  logic [CH_NUM-1:0]    mask_q, mask_d;
  logic [CW-1:0]        mux_q, mux_d;
  logic [SETW-1:0]      set_q, set_d;
  logic                 busy_q, busy_d;
  logic                 eoc_q, eoc_d;
  logic                 scan_done_q, scan_done_d;
  logic [ADC_WIDTH-1:0] dout_q, dout_d;
  logic [CW-1:0]        dch_q, dch_d;

  logic                 load, step, last_bit;
  logic [ADC_WIDTH-1:0] result;
  ch_pick_t             pick_lo, pick_nx;

`ifdef SAR_AVG_EN
  localparam int RW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int ACC_W = ADC_WIDTH + AVG_LOG2;
  logic [RW-1:0]    rep_q, rep_d;
  logic [ACC_W-1:0] sum_q, sum_d;
`else
  // Averaging depth only matters when the accumulator is built.
  localparam int avg_log2_unused = AVG_LOG2;
`endif

  sar_adc_core #(.ADC_WIDTH(ADC_WIDTH)) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .step     (step),
    .cmp      (cmp),
    .DACF     (DACF),
    .result   (result),
    .last_bit (last_bit)
  );

  always_comb begin
    pick_lo     = next_ch(MAX_CH'(ch_mask), -1);
    pick_nx     = next_ch(MAX_CH'(mask_q), int'(mux_q));
    state_d     = state_q;
    mask_d      = mask_q;
    mux_d       = mux_q;
    set_d       = set_q;
    busy_d      = busy_q;
    eoc_d       = 1'b0;
    scan_done_d = 1'b0;
    dout_d      = dout_q;
    dch_d       = dch_q;
    load        = 1'b0;
    step        = 1'b0;
`ifdef SAR_AVG_EN
    rep_d       = rep_q;
    sum_d       = sum_q;
`endif
    case (state_q)
      IDLE: begin
        if (start && (ch_mask != '0)) begin
          mask_d  = ch_mask;
          mux_d   = pick_lo.ch[CW-1:0];
          set_d   = '0;
          busy_d  = 1'b1;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (set_q == SETW'(SETTLE_CYC - 1)) begin
          load    = 1'b1;
          state_d = CONV;
        end else begin
          set_d = set_q + 1'b1;
        end
      end
      CONV: begin
        step = 1'b1;
        if (last_bit) begin
`ifdef SAR_AVG_EN
          // result bit 0 is still clear here, so OR-ing cmp gives the finished code
          sum_d = sum_q + ACC_W'(result | ADC_WIDTH'(cmp));
          if (rep_q != RW'((1 << AVG_LOG2) - 1)) begin
            load  = 1'b1;
            rep_d = rep_q + 1'b1;
          end else begin
            state_d = DONE;
          end
`else
          state_d = DONE;
`endif
        end
      end
      DONE: begin
        eoc_d = 1'b1;
        dch_d = mux_q;
`ifdef SAR_AVG_EN
        dout_d = sum_q[ACC_W-1:AVG_LOG2];
        sum_d  = '0;
        rep_d  = '0;
`else
        dout_d = result;
`endif
        set_d = '0;
        if (pick_nx.found) begin
          mux_d   = pick_nx.ch[CW-1:0];
          state_d = SETTLE;
        end else begin
          scan_done_d = 1'b1;
          if (cont && (ch_mask != '0)) begin
            mask_d  = ch_mask;
            mux_d   = pick_lo.ch[CW-1:0];
            state_d = SETTLE;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mask_q      <= '0;
      mux_q       <= '0;
      set_q       <= '0;
      busy_q      <= 1'b0;
      eoc_q       <= 1'b0;
      scan_done_q <= 1'b0;
      dout_q      <= '0;
      dch_q       <= '0;
`ifdef SAR_AVG_EN
      rep_q       <= '0;
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      mux_q       <= mux_d;
      set_q       <= set_d;
      busy_q      <= busy_d;
      eoc_q       <= eoc_d;
      scan_done_q <= scan_done_d;
      dout_q      <= dout_d;
      dch_q       <= dch_d;
`ifdef SAR_AVG_EN
      rep_q       <= rep_d;
      sum_q       <= sum_d;
`endif
    end
  end

  assign mux_sel   = mux_q;
  assign busy      = busy_q;
  assign eoc       = eoc_q;
  assign den       = eoc_q;
  assign Dout      = dout_q;
  assign Dch       = dch_q;
  assign scan_done = scan_done_q;

endmodule
